// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage core.
// The block watches the decode operands and the instruction held in ID/EX.
// It generates PC/IF-ID holds, ID/EX bubbles and IF/ID + ID/EX flushes.
// These controls resolve load-use and taken-branch hazards.
// It also keeps saturating stall and flush event counters for the debug view.
module hazard_controller #(
  parameter int unsigned LOAD_STALL = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_reg_wr_addr_i,
  input  logic             ex_reg_wr_sig_i,
  input  logic             ex_is_load_i,
  input  logic             br_taken_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             id_ex_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {
    RUN     = 1'b0,
    LU_WAIT = 1'b1
  } state_e;

  // The first bubble is issued from RUN; LU_WAIT covers the remaining ones.
  localparam logic [3:0] REM_INIT = 4'(LOAD_STALL - 1);
  localparam bit         MULTI    = (LOAD_STALL > 1);

  state_e           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic rs1_hit, rs2_hit, hz;
  logic stall_act, flush_act;

  // Load-use hazard: ID/EX load writes a non-x0 register that decode reads
  always_comb begin
    rs1_hit = id_rs1_used_i & (id_rs1_addr_i == ex_reg_wr_addr_i);
    rs2_hit = id_rs2_used_i & (id_rs2_addr_i == ex_reg_wr_addr_i);
    hz      = ex_is_load_i & ex_reg_wr_sig_i & (ex_reg_wr_addr_i != 5'd0)
              & (rs1_hit | rs2_hit);
  end

  // State and remaining-bubble register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic: a taken branch always returns to RUN and clears rem
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      RUN: begin
        if (!br_taken_i && hz && MULTI) begin
          state_d = LU_WAIT;
          rem_d   = REM_INIT;
        end
      end
      LU_WAIT: begin
        if (br_taken_i) begin
          state_d = RUN;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = RUN;
          end
        end
      end
      default: begin
        state_d = RUN;
        rem_d   = '0;
      end
    endcase
  end

  // Mealy control outputs: flush beats stall, everything forced low in reset
  always_comb begin
    flush_act     = reset_n & br_taken_i;
    stall_act     = reset_n & ~br_taken_i & ((state_q == LU_WAIT) | hz);
    pc_stall_o    = stall_act;
    if_id_stall_o = stall_act;
    id_ex_stall_o = stall_act;
    if_id_flush_o = flush_act;
    id_ex_flush_o = flush_act;
  end

  // Saturating event counter next values
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_act && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_act && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Event counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller.
// Instance A: LOAD_STALL=1, CNT_W=16. Instance B: LOAD_STALL=3, CNT_W=2.
// Each directed vector pushes hand-computed expectations for both instances.
// A monitor pops and compares them on the falling edge.
module tb_hazard_controller;

  localparam logic [4:0] ST = 5'b11100;  // pc, if_id, id_ex stall
  localparam logic [4:0] FL = 5'b00011;  // if_id, id_ex flush
  localparam logic [4:0] NO = 5'b00000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, wr = 1'b0, ld = 1'b0, br = 1'b0;

  logic        a_pc, a_ifs, a_ids, a_iff, a_idf;
  logic        b_pc, b_ifs, b_ids, b_iff, b_idf;
  logic [15:0] a_sc, a_fc;
  logic [1:0]  b_sc, b_fc;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         idx;
    logic [4:0] ca;
    int         sa;
    int         fa;
    logic [4:0] cb;
    int         sb;
    int         fb;
  } exp_t;

  exp_t sb_q[$];
  int   vec_n = 0;

  always #5 clk = ~clk;

  hazard_controller #(.LOAD_STALL(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_reg_wr_addr_i(rd), .ex_reg_wr_sig_i(wr), .ex_is_load_i(ld),
    .br_taken_i(br),
    .pc_stall_o(a_pc), .if_id_stall_o(a_ifs), .id_ex_stall_o(a_ids),
    .if_id_flush_o(a_iff), .id_ex_flush_o(a_idf),
    .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
  );

  hazard_controller #(.LOAD_STALL(3), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2),
    .ex_reg_wr_addr_i(rd), .ex_reg_wr_sig_i(wr), .ex_is_load_i(ld),
    .br_taken_i(br),
    .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .id_ex_stall_o(b_ids),
    .if_id_flush_o(b_iff), .id_ex_flush_o(b_idf),
    .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
  );

  task automatic chk(input int idx, input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL vec%0d %s: got %0d expected %0d", idx, nm, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, compare on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.idx, "A_ctrl", int'({a_pc, a_ifs, a_ids, a_iff, a_idf}), int'(e.ca));
        chk(e.idx, "A_stall_cnt", int'(a_sc), e.sa);
        chk(e.idx, "A_flush_cnt", int'(a_fc), e.fa);
        chk(e.idx, "B_ctrl", int'({b_pc, b_ifs, b_ids, b_iff, b_idf}), int'(e.cb));
        chk(e.idx, "B_stall_cnt", int'(b_sc), e.sb);
        chk(e.idx, "B_flush_cnt", int'(b_fc), e.fb);
      end
    end
  end

  task automatic step(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                      input logic uu1, input logic uu2, input logic [4:0] d,
                      input logic w, input logic l, input logic b,
                      input logic [4:0] ca, input int sa, input int fa,
                      input logic [4:0] cb, input int sbv, input int fb);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n = rst;
    rs1 = r1; rs2 = r2; u1 = uu1; u2 = uu2;
    rd = d; wr = w; ld = l; br = b;
    e.idx = vec_n; e.ca = ca; e.sa = sa; e.fa = fa;
    e.cb = cb; e.sb = sbv; e.fb = fb;
    sb_q.push_back(e);
    vec_n++;
  endtask

  // lw x5 in EX, decode reads x5 through rs1
  task automatic haz(input logic rst, input logic b,
                     input logic [4:0] ca, input int sa, input int fa,
                     input logic [4:0] cb, input int sbv, input int fb);
    step(rst, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, b, ca, sa, fa, cb, sbv, fb);
  endtask

  // EX holds a bubble, decode reads nothing relevant
  task automatic idle(input logic b,
                      input logic [4:0] ca, input int sa, input int fa,
                      input logic [4:0] cb, input int sbv, input int fb);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, b, ca, sa, fa, cb, sbv, fb);
  endtask

  initial begin
    int guard;
    // reset held: outputs gated low even with hazard and branch present
    haz(1'b0, 1'b1, NO, 0, 0, NO, 0, 0);
    idle(1'b0, NO, 0, 0, NO, 0, 0);
    // basic load-use: A one bubble, B three bubbles
    haz(1'b1, 1'b0, ST, 0, 0, ST, 0, 0);
    idle(1'b0, NO, 1, 0, ST, 1, 0);
    idle(1'b0, NO, 1, 0, ST, 2, 0);
    idle(1'b0, NO, 1, 0, NO, 3, 0);
    // rd = x0 never stalls
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, NO, 1, 0, NO, 3, 0);
    // rs2 matches but rs2 unused
    step(1'b1, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, NO, 1, 0, NO, 3, 0);
    // no write-back, or not a load
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, NO, 1, 0, NO, 3, 0);
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, NO, 1, 0, NO, 3, 0);
    // branch with hazard in RUN: flush wins
    haz(1'b1, 1'b1, FL, 1, 0, FL, 3, 0);
    idle(1'b0, NO, 1, 1, NO, 3, 1);
    // hazard via rs2; B stall counter already saturated at 3
    step(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, ST, 1, 1, ST, 3, 1);
    idle(1'b0, NO, 2, 1, ST, 3, 1);
    // branch in B's second LU_WAIT cycle
    idle(1'b1, FL, 2, 1, FL, 3, 1);
    idle(1'b0, NO, 2, 2, NO, 3, 2);
    // back-to-back loads retrigger
    haz(1'b1, 1'b0, ST, 2, 2, ST, 3, 2);
    haz(1'b1, 1'b0, ST, 3, 2, ST, 3, 2);
    haz(1'b1, 1'b0, ST, 4, 2, ST, 3, 2);
    haz(1'b1, 1'b0, ST, 5, 2, ST, 3, 2);
    idle(1'b0, NO, 6, 2, ST, 3, 2);
    // reset pulse while B is in LU_WAIT
    haz(1'b0, 1'b0, NO, 0, 0, NO, 0, 0);
    idle(1'b0, NO, 0, 0, NO, 0, 0);
    // flush counter saturation on B
    idle(1'b1, FL, 0, 0, FL, 0, 0);
    idle(1'b1, FL, 0, 1, FL, 0, 1);
    idle(1'b1, FL, 0, 2, FL, 0, 2);
    idle(1'b1, FL, 0, 3, FL, 0, 3);
    idle(1'b0, NO, 0, 4, NO, 0, 3);
    // drain the scoreboard within a bounded number of cycles
    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
